// File: rtl/pdm_duty_sched.sv
// Stereo sample-to-duty scheduler: buffers one L/R pair, converts it to offset-binary
// duty on a fixed sample tick, and ramps both duties to/from midscale for pop-free start and mute.
module pdm_duty_sched #(
    parameter int unsigned TICK_DIV  = 1024,
    parameter logic [15:0] RAMP_STEP = 16'h0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        smpl_vld,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rght_smpl,
    output logic        smpl_rdy,
    input  logic        mute,
    output logic [15:0] lft_duty,
    output logic [15:0] rght_duty,
    output logic        upd,
    output logic        underrun,
    output logic [1:0]  state
);

    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 16;
    localparam logic [DW-1:0]    MID     = 16'h8000;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RAMP_UP = 2'b00,
        ST_RUN     = 2'b01,
        ST_MUTE_DN = 2'b10,
        ST_MUTED   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buf_full_q, buf_full_d;
    logic [DW-1:0]    buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DW-1:0]    lft_q, lft_d, rght_q, rght_d;
    logic             upd_q, upd_d, und_q, und_d;
    logic             tick, capture, consume;
    logic [DW-1:0]    lft_step, rght_step;
    logic             step_at_mid;

    // One ramp step toward midscale in 17 bits, clamped so it never crosses MID.
    function automatic logic [DW-1:0] step_to_mid(input logic [DW-1:0] d);
        logic [DW:0] up;
        logic [DW:0] dn;
        up = {1'b0, d} + {1'b0, RAMP_STEP};
        dn = {1'b0, d} - {1'b0, RAMP_STEP};
        if (d < MID) begin
            return (up >= {1'b0, MID}) ? MID : up[DW-1:0];
        end else if (d > MID) begin
            return (dn[DW] || (dn[DW-1:0] <= MID)) ? MID : dn[DW-1:0];
        end
        return MID;
    endfunction

    assign tick        = (cnt_q == CNT_MAX);
    assign capture     = smpl_vld & ~buf_full_q;
    assign consume     = tick & (state_q != ST_RAMP_UP);
    assign lft_step    = step_to_mid(lft_q);
    assign rght_step   = step_to_mid(rght_q);
    assign step_at_mid = (lft_step == MID) && (rght_step == MID);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RAMP_UP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; transitions only on tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_RAMP_UP: if (step_at_mid) state_d = mute ? ST_MUTED : ST_RUN;
                ST_RUN:     if (mute) state_d = ST_MUTE_DN;
                ST_MUTE_DN: begin
                    if (!mute) begin
                        state_d = ST_RUN;
                    end else if (step_at_mid) begin
                        state_d = ST_MUTED;
                    end
                end
                ST_MUTED:   if (!mute) state_d = ST_RUN;
                default:    state_d = ST_RAMP_UP;
            endcase
        end
    end

    // Output logic: next duty values and status pulses.
    always_comb begin
        lft_d  = lft_q;
        rght_d = rght_q;
        upd_d  = 1'b0;
        und_d  = 1'b0;
        if (tick) begin
            upd_d = 1'b1;
            unique case (state_q)
                ST_RAMP_UP: begin
                    lft_d  = lft_step;
                    rght_d = rght_step;
                end
                ST_RUN: begin
                    if (mute) begin
                        lft_d  = lft_step;
                        rght_d = rght_step;
                    end else if (buf_full_q) begin
                        lft_d  = buf_l_q ^ MID;
                        rght_d = buf_r_q ^ MID;
                    end else begin
                        und_d = 1'b1;
                    end
                end
                ST_MUTE_DN: begin
                    if (!mute) begin
                        if (buf_full_q) begin
                            lft_d  = buf_l_q ^ MID;
                            rght_d = buf_r_q ^ MID;
                        end
                    end else begin
                        lft_d  = lft_step;
                        rght_d = rght_step;
                    end
                end
                ST_MUTED: begin
                    lft_d  = MID;
                    rght_d = MID;
                end
                default: ;
            endcase
        end
    end

    // Tick counter and one-entry pair buffer; capture only happens when empty.
    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        if (capture) begin
            buf_full_d = 1'b1;
            buf_l_d    = lft_smpl;
            buf_r_d    = rght_smpl;
        end else if (consume) begin
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
            upd_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            upd_q      <= upd_d;
            und_q      <= und_d;
        end
    end

    assign smpl_rdy  = ~buf_full_q;
    assign lft_duty  = lft_q;
    assign rght_duty = rght_q;
    assign upd       = upd_q;
    assign underrun  = und_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pdm_duty_sched.sv
// Bench for pdm_duty_sched: directed scenarios with fixed expectations, then random
// stimulus compared every cycle against a tick-level behavioural model.
module tb_pdm_duty_sched;

    localparam int unsigned TD   = 4;
    localparam int          STEP = 16384;
    localparam int          MIDV = 32768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smpl_vld = 1'b0;
    logic [15:0] lft_smpl = '0;
    logic [15:0] rght_smpl = '0;
    logic        mute = 1'b0;
    logic        smpl_rdy, upd, underrun;
    logic [15:0] lft_duty, rght_duty;
    logic [1:0]  state;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Behavioural model: sample counter, state code, duties as integers, pair queue.
    int          m_cnt = 0;
    int          m_st  = 0;
    int          m_l   = 0;
    int          m_r   = 0;
    bit          m_upd = 0;
    bit          m_und = 0;
    logic [31:0] m_q[$];

    pdm_duty_sched #(.TICK_DIV(TD), .RAMP_STEP(16'h4000)) dut (
        .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .lft_smpl(lft_smpl),
        .rght_smpl(rght_smpl), .smpl_rdy(smpl_rdy), .mute(mute),
        .lft_duty(lft_duty), .rght_duty(rght_duty), .upd(upd),
        .underrun(underrun), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int toward_mid(input int d);
        if (d < MIDV) return (d + STEP > MIDV) ? MIDV : d + STEP;
        if (d > MIDV) return (d - STEP < MIDV) ? MIDV : d - STEP;
        return d;
    endfunction

    // Advance the model by one clock using the inputs now applied, then clock the DUT.
    task automatic cyc();
        bit tick, cap, have;
        int old_st;
        tick = (m_cnt == int'(TD) - 1);
        cap  = smpl_vld && (m_q.size() == 0);
        if (rst) begin
            m_cnt = 0; m_st = 0; m_l = 0; m_r = 0; m_upd = 0; m_und = 0;
            m_q.delete();
        end else begin
            m_upd = tick;
            m_und = 0;
            if (tick) begin
                have   = (m_q.size() > 0);
                old_st = m_st;
                case (m_st)
                    0: begin
                        m_l = toward_mid(m_l); m_r = toward_mid(m_r);
                        if (m_l == MIDV && m_r == MIDV) m_st = mute ? 3 : 1;
                    end
                    1: begin
                        if (mute) begin
                            m_l = toward_mid(m_l); m_r = toward_mid(m_r); m_st = 2;
                        end else if (have) begin
                            m_l = int'(m_q[0][31:16] ^ 16'h8000);
                            m_r = int'(m_q[0][15:0] ^ 16'h8000);
                        end else begin
                            m_und = 1;
                        end
                    end
                    2: begin
                        if (!mute) begin
                            m_st = 1;
                            if (have) begin
                                m_l = int'(m_q[0][31:16] ^ 16'h8000);
                                m_r = int'(m_q[0][15:0] ^ 16'h8000);
                            end
                        end else begin
                            m_l = toward_mid(m_l); m_r = toward_mid(m_r);
                            if (m_l == MIDV && m_r == MIDV) m_st = 3;
                        end
                    end
                    default: begin
                        m_l = MIDV; m_r = MIDV;
                        if (!mute) m_st = 1;
                    end
                endcase
                if (old_st != 0) m_q.delete();
            end
            if (cap) m_q.push_back({lft_smpl, rght_smpl});
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_upd(output bit ok, output bit saw_und);
        ok = 0;
        saw_und = 0;
        for (int i = 0; i < 3 * int'(TD); i++) begin
            cyc();
            if (underrun === 1'b1) saw_und = 1;
            if (upd === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r, output bit ok);
        bit c;
        smpl_vld = 1'b1; lft_smpl = l; rght_smpl = r; ok = 0;
        for (int i = 0; i < 3 * int'(TD); i++) begin
            c = (m_q.size() == 0);
            cyc();
            if (c) begin
                ok = 1;
                break;
            end
        end
        smpl_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        tot_cnt++;
        if ({lft_duty, rght_duty} !== 32'h0) $display("FAIL reset_duty: got %h expected 00000000", {lft_duty, rght_duty});
        else pass_cnt++;
        tot_cnt++;
        if ({state, upd, underrun, smpl_rdy} !== 5'b00001) $display("FAIL reset_ctrl: got %b expected 00001", {state, upd, underrun, smpl_rdy});
        else pass_cnt++;
    endtask

    task automatic test_powerup();
        bit ok, su1, su2;
        rst = 1'b0; mute = 1'b0;
        wait_upd(ok, su1);
        tot_cnt++;
        if (!ok || {lft_duty, rght_duty, state} !== {32'h4000_4000, 2'b00}) $display("FAIL ramp_step1: got %h/%h st %b expected 4000/4000 st 00", lft_duty, rght_duty, state);
        else pass_cnt++;
        wait_upd(ok, su2);
        tot_cnt++;
        if (!ok || {lft_duty, rght_duty, state} !== {32'h8000_8000, 2'b01}) $display("FAIL ramp_step2: got %h/%h st %b expected 8000/8000 st 01", lft_duty, rght_duty, state);
        else pass_cnt++;
        tot_cnt++;
        if (su1 || su2) $display("FAIL ramp_no_underrun: got underrun expected none");
        else pass_cnt++;
    endtask

    task automatic test_conversion();
        bit ok, okw, su;
        send(16'h7FFF, 16'h8000, ok);
        wait_upd(okw, su);
        tot_cnt++;
        if (!ok || !okw || {lft_duty, rght_duty} !== 32'hFFFF_0000) $display("FAIL conv_extremes: got %h/%h expected FFFF/0000", lft_duty, rght_duty);
        else pass_cnt++;
        send(16'h0000, 16'h0000, ok);
        wait_upd(okw, su);
        tot_cnt++;
        if (!ok || !okw || {lft_duty, rght_duty} !== 32'h8000_8000) $display("FAIL conv_zero: got %h/%h expected 8000/8000", lft_duty, rght_duty);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] pl[3];
        logic [15:0] pr[3];
        int  ns, nr;
        bit  c;
        pl = '{16'h1000, 16'h2345, 16'hF00D};
        pr = '{16'hA000, 16'h0777, 16'h3C3C};
        ns = 0; nr = 0;
        smpl_vld = 1'b1;
        for (int i = 0; i < 12 * int'(TD) && nr < 3; i++) begin
            if (ns < 3) begin
                lft_smpl = pl[ns]; rght_smpl = pr[ns];
            end
            c = smpl_vld && (m_q.size() == 0);
            cyc();
            if (c) begin
                ns++;
                if (ns == 3) smpl_vld = 1'b0;
                tot_cnt++;
                if (smpl_rdy !== 1'b0) $display("FAIL bp_rdy_low: got %b expected 0 after capture %0d", smpl_rdy, ns);
                else pass_cnt++;
            end
            if (upd === 1'b1 && nr < 3) begin
                tot_cnt++;
                if ({lft_duty, rght_duty} !== {pl[nr] ^ 16'h8000, pr[nr] ^ 16'h8000}) $display("FAIL bp_order: got %h/%h expected %h/%h", lft_duty, rght_duty, pl[nr] ^ 16'h8000, pr[nr] ^ 16'h8000);
                else pass_cnt++;
                nr++;
            end
        end
        smpl_vld = 1'b0;
        tot_cnt++;
        if (nr != 3) $display("FAIL bp_count: got %0d pairs expected 3", nr);
        else pass_cnt++;
    endtask

    task automatic test_underrun();
        bit ok, okw, su;
        int und_n;
        bit coincide, held;
        send(16'h9234, 16'h9234, ok);
        wait_upd(okw, su);
        und_n = 0; coincide = 1; held = 0;
        for (int i = 0; i < int'(TD); i++) begin
            cyc();
            if (underrun === 1'b1) begin
                und_n++;
                if (upd !== 1'b1) coincide = 0;
            end
            if (upd === 1'b1) held = ({lft_duty, rght_duty} === 32'h1234_1234);
        end
        tot_cnt++;
        if (!ok || !okw || !held) $display("FAIL underrun_hold: got %h/%h expected 1234/1234", lft_duty, rght_duty);
        else pass_cnt++;
        tot_cnt++;
        if (und_n != 1 || !coincide) $display("FAIL underrun_pulse: got %0d pulses coincident=%0d expected 1 coincident=1", und_n, coincide);
        else pass_cnt++;
    endtask

    task automatic test_mute_ramp();
        bit ok, okw, su;
        send(16'h7FFF, 16'h7FFF, ok);
        wait_upd(okw, su);
        mute = 1'b1;
        wait_upd(okw, su);
        tot_cnt++;
        if (!okw || {lft_duty, rght_duty, state} !== {32'hBFFF_BFFF, 2'b10}) $display("FAIL mute_step1: got %h/%h st %b expected BFFF/BFFF st 10", lft_duty, rght_duty, state);
        else pass_cnt++;
        wait_upd(okw, su);
        tot_cnt++;
        if (!okw || {lft_duty, rght_duty, state} !== {32'h8000_8000, 2'b11}) $display("FAIL mute_clamp: got %h/%h st %b expected 8000/8000 st 11", lft_duty, rght_duty, state);
        else pass_cnt++;
        send(16'h5555, 16'h5555, ok);
        wait_upd(okw, su);
        tot_cnt++;
        if (!okw || smpl_rdy !== 1'b1 || {lft_duty, state} !== {16'h8000, 2'b11}) $display("FAIL muted_discard: got rdy %b %h st %b expected rdy 1 8000 st 11", smpl_rdy, lft_duty, state);
        else pass_cnt++;
        mute = 1'b0;
        wait_upd(okw, su);
        tot_cnt++;
        if (!okw || {lft_duty, state} !== {16'h8000, 2'b01}) $display("FAIL unmute_trans: got %h st %b expected 8000 st 01", lft_duty, state);
        else pass_cnt++;
        send(16'h0100, 16'h0100, ok);
        wait_upd(okw, su);
        tot_cnt++;
        if (!ok || !okw || {lft_duty, rght_duty} !== 32'h8100_8100) $display("FAIL unmute_apply: got %h/%h expected 8100/8100", lft_duty, rght_duty);
        else pass_cnt++;
    endtask

    task automatic test_vld_on_tick();
        bit okw, su;
        for (int i = 0; i < 2 * int'(TD) && m_cnt != int'(TD) - 1; i++) cyc();
        smpl_vld = 1'b1; lft_smpl = 16'h1111; rght_smpl = 16'h2222;
        cyc();
        smpl_vld = 1'b0;
        tot_cnt++;
        if ({upd, underrun, lft_duty, rght_duty} !== {2'b11, 32'h8100_8100}) $display("FAIL tick_capture_und: got %b%b %h/%h expected 11 8100/8100", upd, underrun, lft_duty, rght_duty);
        else pass_cnt++;
        wait_upd(okw, su);
        tot_cnt++;
        if (!okw || su || {lft_duty, rght_duty} !== 32'h9111_A222) $display("FAIL tick_capture_apply: got %h/%h und %b expected 9111/A222 und 0", lft_duty, rght_duty, su);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_ramp();
        bit ok, okw, su;
        send(16'h7FFF, 16'h7FFF, ok);
        wait_upd(okw, su);
        mute = 1'b1;
        wait_upd(okw, su);
        tot_cnt++;
        if (!okw || state !== 2'b10) $display("FAIL rst_pre_state: got %b expected 10", state);
        else pass_cnt++;
        rst = 1'b1;
        cyc();
        rst = 1'b0; mute = 1'b0;
        tot_cnt++;
        if ({lft_duty, rght_duty, state, upd} !== {32'h0, 2'b00, 1'b0}) $display("FAIL rst_mid_ramp: got %h/%h st %b upd %b expected 0000/0000 st 00 upd 0", lft_duty, rght_duty, state, upd);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [36:0] exp_v, got_v;
        int errs;
        errs = 0;
        for (int i = 0; i < 1200; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            smpl_vld  = ($urandom_range(0, 2) == 0);
            lft_smpl  = 16'($urandom);
            rght_smpl = 16'($urandom);
            if ($urandom_range(0, 39) == 0) mute = ~mute;
            cyc();
            exp_v = {2'(m_st), m_upd, m_und, 16'(m_l), 16'(m_r), (m_q.size() == 0)};
            got_v = {state, upd, underrun, lft_duty, rght_duty, smpl_rdy};
            tot_cnt++;
            if (got_v !== exp_v) begin
                if (errs < 10) $display("FAIL random_cyc%0d: got %h expected %h", i, got_v, exp_v);
                errs++;
            end else begin
                pass_cnt++;
            end
        end
        rst = 1'b0; smpl_vld = 1'b0; mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_conversion();
        test_back_to_back();
        test_underrun();
        test_mute_ramp();
        test_vld_on_tick();
        test_reset_mid_ramp();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
